// File: rtl/fifo_sync.sv
// fifo_sync: parametrised single-clock FIFO with registered read data,
// occupancy count, full/empty and programmable almost-full/almost-empty flags,
// and one-cycle overflow/underflow error pulses.
//
// Pointers carry one extra wrap bit so that full and empty can be told apart
// when the low address bits coincide. Flags and count are decoded from the
// registered pointers only, so no input reaches an output combinationally.
module fifo_sync #(
    parameter int unsigned SIZE_DATA = 8,
    parameter int unsigned SIZE_ADDR = 3,
    parameter int unsigned AF_TH     = (2 ** SIZE_ADDR) - 1,
    parameter int unsigned AE_TH     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic                 i_rd_en,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
    output logic [SIZE_ADDR:0]   o_count,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam int unsigned DEPTH = 2 ** SIZE_ADDR;
    localparam int unsigned PTR_W = SIZE_ADDR + 1;

    // Pointer, storage and output registers
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_d;
    logic [SIZE_DATA-1:0] mem_q [DEPTH];
    logic [SIZE_DATA-1:0] data_q;
    logic [SIZE_DATA-1:0] data_d;
    logic                 overflow_q;
    logic                 overflow_d;
    logic                 underflow_q;
    logic                 underflow_d;

    // Decoded status
    logic [SIZE_ADDR-1:0] wr_addr_c;
    logic [SIZE_ADDR-1:0] rd_addr_c;
    logic [PTR_W-1:0]     count_c;
    logic                 full_c;
    logic                 empty_c;
    logic                 rd_ok_c;
    logic                 wr_ok_c;

    // Status decode from the registered pointers
    assign wr_addr_c = wr_ptr_q[SIZE_ADDR-1:0];
    assign rd_addr_c = rd_ptr_q[SIZE_ADDR-1:0];
    assign count_c   = wr_ptr_q - rd_ptr_q;
    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_addr_c == rd_addr_c) &&
                       (wr_ptr_q[SIZE_ADDR] != rd_ptr_q[SIZE_ADDR]);

    // Request acceptance: no write-to-read bypass; a full FIFO takes a write
    // only when a read frees a slot in the same cycle
    assign rd_ok_c = i_rd_en && !empty_c;
    assign wr_ok_c = i_wr_en && (!full_c || rd_ok_c);

    // Next-state for pointers, read data and error pulses
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_d      = data_q;
        overflow_d  = i_wr_en && !wr_ok_c;
        underflow_d = i_rd_en && !rd_ok_c;
        if (wr_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            data_d   = mem_q[rd_addr_c];
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_q      <= data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, not reset; a same-address read in this cycle sees the old word
    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_ok_c) begin
            mem_q[wr_addr_c] <= i_data;
        end
    end

    // Output mapping
    assign o_data         = data_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;
    assign o_count        = count_c;
    assign o_full         = full_c;
    assign o_empty        = empty_c;
    assign o_almost_full  = (count_c >= PTR_W'(AF_TH));
    assign o_almost_empty = (count_c <= PTR_W'(AE_TH));

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed scenarios on a default-size
// instance and a randomized wrap-around soak on a 4-deep instance checked
// against a queue-based reference model.
module tb_fifo_sync;

    logic clk;
    int   n_checks;
    int   n_fail;

    // Default-parameter instance (DEPTH 8, AF_TH 7, AE_TH 1)
    logic       m_rst_n, m_wr, m_rd;
    logic [7:0] m_din, m_dout;
    logic       m_full, m_empty, m_af, m_ae, m_ov, m_un;
    logic [3:0] m_cnt;

    // Small instance for the soak (DEPTH 4, AF_TH 3, AE_TH 1)
    logic       s_rst_n, s_wr, s_rd;
    logic [7:0] s_din, s_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic [2:0] s_cnt;

    fifo_sync u_main (
        .i_clk(clk), .i_rst_n(m_rst_n), .i_wr_en(m_wr), .i_data(m_din), .i_rd_en(m_rd),
        .o_data(m_dout), .o_full(m_full), .o_empty(m_empty), .o_almost_full(m_af),
        .o_almost_empty(m_ae), .o_count(m_cnt), .o_overflow(m_ov), .o_underflow(m_un)
    );

    fifo_sync #(.SIZE_DATA(8), .SIZE_ADDR(2), .AF_TH(3), .AE_TH(1)) u_soak (
        .i_clk(clk), .i_rst_n(s_rst_n), .i_wr_en(s_wr), .i_data(s_din), .i_rd_en(s_rd),
        .o_data(s_dout), .o_full(s_full), .o_empty(s_empty), .o_almost_full(s_af),
        .o_almost_empty(s_ae), .o_count(s_cnt), .o_overflow(s_ov), .o_underflow(s_un)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle on the main instance; return 1 time unit after the edge
    task automatic m_cycle(input logic wr, input logic [7:0] d, input logic rd);
        m_wr = wr; m_din = d; m_rd = rd;
        @(posedge clk);
        #1;
        m_wr = 1'b0; m_rd = 1'b0;
    endtask

    task automatic test_reset;
        m_rst_n = 1'b0;
        m_cycle(1'b1, 8'hFF, 1'b1);
        m_rst_n = 1'b0;
        m_cycle(1'b1, 8'hFF, 1'b1);
        n_checks++; if (m_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", m_empty); end
        n_checks++; if (m_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", m_full); end
        n_checks++; if (m_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", m_cnt); end
        n_checks++; if (m_dout !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", m_dout); end
        n_checks++; if (m_ov !== 1'b0 || m_un !== 1'b0) begin n_fail++; $display("FAIL reset_err got ov=%b un=%b exp 0/0", m_ov, m_un); end
        n_checks++; if (m_ae !== 1'b1 || m_af !== 1'b0) begin n_fail++; $display("FAIL reset_almost got ae=%b af=%b exp 1/0", m_ae, m_af); end
        m_rst_n = 1'b1;
        m_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 8; i++) begin
            m_cycle(1'b1, 8'(8'h10 + i), 1'b0);
            n_checks++; if (m_cnt !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, m_cnt, i + 1); end
            n_checks++; if (m_af !== ((i + 1) >= 7)) begin n_fail++; $display("FAIL fill_af[%0d] got %b exp %b", i, m_af, (i + 1) >= 7); end
            n_checks++; if (m_full !== (i == 7)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, m_full, i == 7); end
            n_checks++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL fill_ov[%0d] got %b exp 0", i, m_ov); end
        end
        m_cycle(1'b1, 8'hAA, 1'b0);
        n_checks++; if (m_ov !== 1'b1) begin n_fail++; $display("FAIL overflow_pulse got %b exp 1", m_ov); end
        n_checks++; if (m_cnt !== 4'd8) begin n_fail++; $display("FAIL overflow_count got %0d exp 8", m_cnt); end
        m_cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL overflow_clear got %b exp 0", m_ov); end
    endtask

    task automatic test_drain_underflow;
        for (int i = 0; i < 8; i++) begin
            m_cycle(1'b0, 8'h00, 1'b1);
            n_checks++; if (m_dout !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, m_dout, 8'(8'h10 + i)); end
            n_checks++; if (m_cnt !== 4'(7 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, m_cnt, 7 - i); end
            n_checks++; if (m_ae !== ((7 - i) <= 1)) begin n_fail++; $display("FAIL drain_ae[%0d] got %b exp %b", i, m_ae, (7 - i) <= 1); end
            n_checks++; if (m_empty !== (i == 7)) begin n_fail++; $display("FAIL drain_empty[%0d] got %b exp %b", i, m_empty, i == 7); end
        end
        m_cycle(1'b0, 8'h00, 1'b1);
        n_checks++; if (m_un !== 1'b1) begin n_fail++; $display("FAIL underflow_pulse got %b exp 1", m_un); end
        n_checks++; if (m_dout !== 8'h17) begin n_fail++; $display("FAIL underflow_hold got %h exp 17", m_dout); end
        m_cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (m_un !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got %b exp 0", m_un); end
    endtask

    task automatic test_full_simul;
        logic [7:0] exp_seq [8];
        for (int i = 0; i < 8; i++) m_cycle(1'b1, 8'(8'h10 + i), 1'b0);
        m_cycle(1'b1, 8'h55, 1'b1);
        n_checks++; if (m_dout !== 8'h10) begin n_fail++; $display("FAIL fullrw_data got %h exp 10", m_dout); end
        n_checks++; if (m_cnt !== 4'd8) begin n_fail++; $display("FAIL fullrw_count got %0d exp 8", m_cnt); end
        n_checks++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL fullrw_ov got %b exp 0", m_ov); end
        for (int i = 0; i < 7; i++) exp_seq[i] = 8'(8'h11 + i);
        exp_seq[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            m_cycle(1'b0, 8'h00, 1'b1);
            n_checks++; if (m_dout !== exp_seq[i]) begin n_fail++; $display("FAIL fullrw_drain[%0d] got %h exp %h", i, m_dout, exp_seq[i]); end
        end
        n_checks++; if (m_empty !== 1'b1) begin n_fail++; $display("FAIL fullrw_empty got %b exp 1", m_empty); end
    endtask

    task automatic test_empty_simul;
        m_cycle(1'b1, 8'h33, 1'b1);
        n_checks++; if (m_un !== 1'b1) begin n_fail++; $display("FAIL emptyrw_un got %b exp 1", m_un); end
        n_checks++; if (m_cnt !== 4'd1) begin n_fail++; $display("FAIL emptyrw_count got %0d exp 1", m_cnt); end
        n_checks++; if (m_empty !== 1'b0) begin n_fail++; $display("FAIL emptyrw_empty got %b exp 0", m_empty); end
        m_cycle(1'b0, 8'h00, 1'b1);
        n_checks++; if (m_dout !== 8'h33) begin n_fail++; $display("FAIL emptyrw_read got %h exp 33", m_dout); end
        n_checks++; if (m_un !== 1'b0 || m_cnt !== 4'd0) begin n_fail++; $display("FAIL emptyrw_after got un=%b cnt=%0d exp 0/0", m_un, m_cnt); end
    endtask

    // Random soak on the 4-deep instance against a queue model
    task automatic test_soak;
        logic [7:0] q[$];
        logic [7:0] e_data;
        logic       e_ov, e_un, rd_ok, wr_ok;
        int         sz;
        s_rst_n = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_din = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        q.delete(); e_data = 8'h00; e_ov = 1'b0; e_un = 1'b0;
        for (int c = 0; c < 40; c++) begin
            s_rst_n = (c == 20) ? 1'b0 : 1'b1;
            s_wr    = ($urandom_range(0, 99) < ((c < 20) ? 70 : 50));
            s_rd    = ($urandom_range(0, 99) < ((c < 20) ? 40 : 50));
            s_din   = 8'($urandom);
            if (!s_rst_n) begin
                q.delete(); e_data = 8'h00; e_ov = 1'b0; e_un = 1'b0;
            end else begin
                rd_ok = s_rd && (q.size() > 0);
                wr_ok = s_wr && ((q.size() < 4) || rd_ok);
                e_ov  = s_wr && !wr_ok;
                e_un  = s_rd && !rd_ok;
                if (rd_ok) e_data = q.pop_front();
                if (wr_ok) q.push_back(s_din);
            end
            @(posedge clk); #1;
            sz = q.size();
            n_checks++; if (s_dout !== e_data) begin n_fail++; $display("FAIL soak_data[%0d] got %h exp %h", c, s_dout, e_data); end
            n_checks++; if (s_cnt !== 3'(sz)) begin n_fail++; $display("FAIL soak_count[%0d] got %0d exp %0d", c, s_cnt, sz); end
            n_checks++; if (s_full !== (sz == 4) || s_empty !== (sz == 0)) begin n_fail++; $display("FAIL soak_fe[%0d] got f=%b e=%b size %0d", c, s_full, s_empty, sz); end
            n_checks++; if (s_af !== (sz >= 3) || s_ae !== (sz <= 1)) begin n_fail++; $display("FAIL soak_almost[%0d] got af=%b ae=%b size %0d", c, s_af, s_ae, sz); end
            n_checks++; if (s_ov !== e_ov || s_un !== e_un) begin n_fail++; $display("FAIL soak_err[%0d] got ov=%b un=%b exp %b/%b", c, s_ov, s_un, e_ov, e_un); end
        end
        s_wr = 1'b0; s_rd = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_rst_n = 1'b0; m_wr = 1'b0; m_rd = 1'b0; m_din = 8'h00;
        s_rst_n = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_din = 8'h00;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_simul();
        test_empty_simul();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Parametrised single-clock FIFO: dual-pointer storage array, registered read data, occupancy count, full/empty and programmable almost-full/almost-empty flags, and overflow/underflow error pulses. It is the buffering stage between producer and consumer logic in the FIFO datapath. Unlike the earlier lookup array, it manages pointers and flags internally and never lets a write block a read.

## Interface
- SIZE_DATA, 8: data word width in bits.
- SIZE_ADDR, 3: address width; depth DEPTH = 2**SIZE_ADDR (8 at default).
- AF_TH, DEPTH-1: o_almost_full asserts when count >= AF_TH. Legal range 1..DEPTH.
- AE_TH, 1: o_almost_empty asserts when count <= AE_TH. Legal range 0..DEPTH-1.
- i_clk, input, 1: clock; all state changes on its rising edge.
- i_rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of i_clk.
- i_wr_en, input, 1: write request.
- i_data, input, SIZE_DATA: write data.
- i_rd_en, input, 1: read request.
- o_data, output, SIZE_DATA: registered read data.
- o_full, output, 1: count == DEPTH.
- o_empty, output, 1: count == 0.
- o_almost_full, output, 1: count >= AF_TH.
- o_almost_empty, output, 1: count <= AE_TH.
- o_count, output, SIZE_ADDR+1: current occupancy, 0..DEPTH.
- o_overflow, output, 1: one-cycle pulse after a rejected write.
- o_underflow, output, 1: one-cycle pulse after a rejected read.

## Operation
- State: wr_ptr and rd_ptr, each SIZE_ADDR+1 bits (the MSB is the wrap bit); storage array of DEPTH x SIZE_DATA.
- Count = wr_ptr - rd_ptr, computed modulo 2**(SIZE_ADDR+1).
  - Full: the low bits of the two pointers are equal and the MSBs differ.
  - Empty: the pointers are fully equal.
- Read accept: rd_ok = i_rd_en && !o_empty. There is no write-to-read bypass, so a read while empty is rejected even if a write occurs in the same cycle.
- Write accept: wr_ok = i_wr_en && (!o_full || rd_ok).
  - When full, a write succeeds only together with an accepted read.
- On wr_ok:
  - mem[wr_ptr[SIZE_ADDR-1:0]] <= i_data.
  - wr_ptr increments, wrapping naturally.
- On rd_ok:
  - o_data <= mem[rd_ptr[SIZE_ADDR-1:0]].
  - rd_ptr increments.
  - When not reading, o_data holds its last value.
- A simultaneous accepted read and write leaves the count unchanged.
  - If the same address is involved (only possible when full), the read returns the old word.
- o_overflow <= i_wr_en && !wr_ok. o_underflow <= i_rd_en && !rd_ok.
  - A rejected request changes no pointer and no storage.
- Flags and o_count are decoded from the registered pointers, so they are glitch-free with respect to the inputs. There is no combinational path from the inputs to any output.
- Storage contents are not reset; only the pointers and output registers are.

## Timing
- Reset (i_rst_n low at an edge) takes priority over all requests. After that edge:
  - wr_ptr = rd_ptr = 0 and o_count = 0.
  - o_empty = 1, o_full = 0.
  - o_almost_empty = 1, o_almost_full = 0.
  - o_data = 0, o_overflow = 0, o_underflow = 0.
- Reset asserted mid-operation discards all contents. Requests present during that edge are ignored and raise no error pulse.
- Read latency is 1 cycle: data for a read accepted at edge N is valid on o_data after edge N, stable until the next accepted read.
- Write-to-read visibility: a word written at edge N clears o_empty after edge N and can be read at edge N+1, appearing on o_data after N+1.
- All flags, o_count and the error pulses update after the same edge that accepts or rejects the request.
- Pointer wrap: after DEPTH writes the low address returns to 0 and the MSB toggles; this is how full and empty are told apart.

## Test plan
- Reset check (default parameters): hold i_rst_n=0 with i_wr_en=i_rd_en=1 for 2 cycles -> o_empty=1, o_count=0, o_data=0, o_overflow=o_underflow=0.
- Fill and overflow: write 0x10..0x17 on 8 consecutive cycles, then one more write of 0xAA.
  - o_almost_full rises after the 7th write and o_full after the 8th.
  - The 9th write pulses o_overflow for 1 cycle; o_count stays 8 and 0xAA is never read out.
- Drain and underflow: read 8 times -> o_data sequence 0x10..0x17, each one cycle after its read.
  - o_almost_empty rises at count 1 and o_empty after the 8th read.
  - A 9th read pulses o_underflow and o_data holds 0x17.
- Full + simultaneous read/write: when full, read and write 0x55 in the same cycle -> o_data=0x10, o_count stays 8, o_overflow=0; 0x55 is read out 8 reads later.
- Empty + simultaneous read/write: when empty, read and write 0x33 in the same cycle -> o_underflow=1, o_count=1; the next read returns 0x33.
- Wrap-around soak: 40 cycles of random enables with SIZE_ADDR=2 and AF_TH=3, checked against a reference model.
  - Data order, o_count and every flag must match every cycle.
  - Reset asserted at cycle 20 must empty the FIFO, and the model is reset alongside it.
